// File: rtl/uart_tx_fifo_param.sv
// uart_tx_fifo_param: 16550-style UART transmitter with an integrated TX FIFO.
// Words pushed over valid/ready are queued, then serialised on tx as
// start / 5..DATA_W data bits / optional parity / 1, 1.5 or 2 stop bits.
// Bit timing comes from an external oversampled baud_pulse (OVS ticks per bit).
module uart_tx_fifo_param #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 16,
  parameter int OVS        = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            baud_pulse,
  input  logic [DATA_W-1:0]               in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  input  logic [$clog2(DATA_W+1)-1:0]     cfg_nbits,
  input  logic                            cfg_pen,
  input  logic                            cfg_eps,
  input  logic                            cfg_stick,
  input  logic                            cfg_stb,
  input  logic                            cfg_msb1st,
  input  logic                            set_break,
  output logic                            tx,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            thre,
  output logic                            temt
);

  localparam int NB_W = $clog2(DATA_W + 1);
  localparam int CW   = $clog2(FIFO_DEPTH + 1);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int BW   = $clog2(DATA_W);
  localparam int TW   = $clog2(2 * OVS);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  // Frame settings still needed after the word has been loaded.
  typedef struct packed {
    logic [NB_W-1:0] nbits;
    logic            pen;
    logic            stb;
  } frame_cfg_t;

  // ---------------------------------------------------------------- FIFO
  logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem;
  logic [AW-1:0]                     wr_ptr, rd_ptr;
  logic [CW-1:0]                     count, count_nxt;
  logic                              push, pop, fifo_ne;

  assign push    = in_valid & in_ready;
  assign fifo_ne = (count != '0);

  // Occupancy after this clock's push/pop.
  always_comb begin
    count_nxt = count;
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // Pointers, count and a registered ready so a freed slot shows up one clk later.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      in_ready <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count    <= count_nxt;
      in_ready <= (count_nxt != CW'(FIFO_DEPTH));
    end
  end

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_data;
  end

  // ------------------------------------------------------ word preparation
  logic [NB_W-1:0]   nbits_eff;
  logic [DATA_W-1:0] head, mask, masked, rev_full, load_word;
  logic [DATA_W-1:0] ones;
  logic              par_calc;

  assign ones = '1;

  // Full-width bit reversal; shifted down below to put the MSB of the used field at bit 0.
  for (genvar g = 0; g < DATA_W; g++) begin : g_rev
    assign rev_full[g] = masked[DATA_W-1-g];
  end

  // Clamp the bit count, mask unused MSBs, order bits so the shifter always sends bit 0 next.
  always_comb begin
    nbits_eff = cfg_nbits;
    if (cfg_nbits < NB_W'(5))           nbits_eff = NB_W'(5);
    else if (cfg_nbits > NB_W'(DATA_W)) nbits_eff = NB_W'(DATA_W);
    head      = mem[rd_ptr];
    mask      = ~(ones << nbits_eff);
    masked    = head & mask;
    load_word = cfg_msb1st ? (rev_full >> (NB_W'(DATA_W) - nbits_eff)) : masked;
    if (cfg_stick) par_calc = ~cfg_eps;
    else           par_calc = cfg_eps ? (^masked) : (~^masked);
  end

  // ---------------------------------------------------------------- FSM
  state_t            state, state_nxt;
  logic [TW-1:0]     cnt, stop_len;
  logic [BW-1:0]     bits_left;
  logic [DATA_W-1:0] shreg;
  logic              par_q;
  frame_cfg_t        cfg_q;
  logic              cnt_zero;
  logic              line;

  assign cnt_zero = (cnt == '0);

  // Stop-bit length in ticks, from the settings latched for this frame.
  always_comb begin
    if (!cfg_q.stb)                  stop_len = TW'(OVS - 1);
    else if (cfg_q.nbits == NB_W'(5)) stop_len = TW'(3 * OVS / 2 - 1);
    else                             stop_len = TW'(2 * OVS - 1);
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next state: moves only on baud ticks, at the end of each bit.
  always_comb begin
    state_nxt = state;
    if (baud_pulse) begin
      case (state)
        S_IDLE:   if (fifo_ne)  state_nxt = S_START;
        S_START:  if (cnt_zero) state_nxt = S_DATA;
        S_DATA:   if (cnt_zero && bits_left == '0) state_nxt = cfg_q.pen ? S_PARITY : S_STOP;
        S_PARITY: if (cnt_zero) state_nxt = S_STOP;
        S_STOP:   if (cnt_zero) state_nxt = S_IDLE;
        default:  state_nxt = S_IDLE;
      endcase
    end
  end

  // Outputs of the FSM: the serial line level and the FIFO pop strobe.
  always_comb begin
    case (state)
      S_START:  line = 1'b0;
      S_DATA:   line = shreg[0];
      S_PARITY: line = par_q;
      default:  line = 1'b1;
    endcase
    pop = baud_pulse && (state == S_IDLE) && fifo_ne;
  end

  // Frame datapath: tick counter, data shifter, parity and latched settings.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt       <= '0;
      bits_left <= '0;
      shreg     <= '0;
      par_q     <= 1'b0;
      cfg_q     <= '0;
    end else if (baud_pulse) begin
      case (state)
        S_IDLE: begin
          if (fifo_ne) begin
            shreg       <= load_word;
            par_q       <= par_calc;
            cfg_q.nbits <= nbits_eff;
            cfg_q.pen   <= cfg_pen;
            cfg_q.stb   <= cfg_stb;
            cnt         <= TW'(OVS - 1);
          end
        end
        S_START: begin
          if (cnt_zero) begin
            cnt       <= TW'(OVS - 1);
            bits_left <= BW'(cfg_q.nbits - 1'b1);
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_DATA: begin
          if (cnt_zero) begin
            if (bits_left != '0) begin
              shreg     <= shreg >> 1;
              bits_left <= bits_left - 1'b1;
              cnt       <= TW'(OVS - 1);
            end else begin
              cnt <= cfg_q.pen ? TW'(OVS - 1) : stop_len;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        S_PARITY: begin
          if (cnt_zero) cnt <= stop_len;
          else          cnt <= cnt - 1'b1;
        end
        S_STOP: begin
          if (!cnt_zero) cnt <= cnt - 1'b1;
        end
        default: cnt <= '0;
      endcase
    end
  end

  // Registered pad driver; break overrides the line without stopping the FSM.
  always_ff @(posedge clk) begin
    if (!rst_n) tx <= 1'b1;
    else        tx <= line & ~set_break;
  end

  assign fifo_count = count;
  assign thre       = (count == '0);
  assign temt       = thre && (state == S_IDLE);

endmodule
